// File: rtl/fetch_redirect_ctrl.sv
// Inst-cache fetch request sequencer: arbitrates flush/redirect sources, holds an unaccepted
// redirect, enforces the idle lock and drops responses to requests cancelled by a redirect.
module fetch_redirect_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        excp_tlbrefill,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic        ertn_flush,
    input  logic [31:0] csr_era,
    input  logic        refetch_flush,
    input  logic        idle_flush,
    input  logic [31:0] ws_pc,
    input  logic        has_int,
    input  logic        br_flush,
    input  logic [31:0] br_target,
    input  logic        seq_req,
    input  logic [31:0] seq_pc,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_addr_ok,
    input  logic        req_data_ok,
    output logic        fetch_accept,
    output logic        resp_valid,
    output logic        resp_drop,
    output logic        redirect_pending,
    output logic        idle_locked,
    output logic [1:0]  outstanding
);

    typedef enum logic [1:0] {StRunBoot, StRun, StPend, StIdle} state_e;

    state_e      state_q;
    logic [31:0] buf_q;
    logic [1:0]  live_q, live_d;
    logic [1:0]  cancel_q, cancel_d;
    logic [2:0]  mask_q;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] ws_next;
    logic        idle_go;
    logic [1:0]  out_cnt;
    logic        has_room;
    logic        want;
    logic        dok;

    assign ws_next = ws_pc + 32'd4;
    assign idle_go = idle_flush && !has_int;
    assign out_cnt = live_q + cancel_q;

    // Fixed-priority redirect source; a branch loses to any pipeline flush.
    always_comb begin
        redir     = 1'b1;
        redir_tgt = br_target;
        if (excp_flush && excp_tlbrefill) begin
            redir_tgt = csr_tlbrentry;
        end else if (excp_flush) begin
            redir_tgt = csr_eentry;
        end else if (ertn_flush) begin
            redir_tgt = csr_era;
        end else if (refetch_flush || idle_flush) begin
            redir_tgt = ws_next;
        end else if (br_flush) begin
            redir_tgt = br_target;
        end else begin
            redir = 1'b0;
        end
    end

    // A same-cycle data_ok frees a slot, so a full pipe can still issue.
    assign has_room = (32'(out_cnt) < MAX_OUTSTANDING) || req_data_ok;
    assign want     = redir || (state_q == StPend) || seq_req || (state_q == StRunBoot);

    assign req_valid    = !reset && want && (state_q != StIdle) && !idle_go && has_room;
    assign fetch_accept = req_valid && req_addr_ok;

    always_comb begin
        req_addr = seq_pc;
        if (reset) begin
            req_addr = RESET_PC;
        end else if (redir) begin
            req_addr = redir_tgt;
        end else if (state_q == StPend) begin
            req_addr = buf_q;
        end else if (state_q == StRunBoot) begin
            req_addr = RESET_PC;
        end
    end

    // Cancelled requests are always older, so they are answered first.
    assign dok        = req_data_ok && !reset;
    assign resp_drop  = dok && (cancel_q != 2'd0);
    assign resp_valid = dok && (cancel_q == 2'd0) && (live_q != 2'd0);

    assign redirect_pending = !reset && (state_q == StPend);
    assign idle_locked      = !reset && (state_q == StIdle);
    assign outstanding      = reset ? 2'd0 : out_cnt;

    always_comb begin
        live_d   = live_q;
        cancel_d = cancel_q;
        if (redir) begin
            cancel_d = out_cnt - {1'b0, resp_valid} - {1'b0, resp_drop};
            live_d   = {1'b0, fetch_accept};
        end else begin
            cancel_d = cancel_q - {1'b0, resp_drop};
            live_d   = live_q + {1'b0, fetch_accept} - {1'b0, resp_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRunBoot;
            buf_q    <= RESET_PC;
            live_q   <= 2'd0;
            cancel_q <= 2'd0;
            mask_q   <= 3'd4;
        end else begin
            live_q   <= live_d;
            cancel_q <= cancel_d;
            if (mask_q != 3'd0) begin
                mask_q <= mask_q - 3'd1;
            end
            if (idle_go) begin
                state_q <= StIdle;
                buf_q   <= ws_next;
            end else if (state_q == StIdle) begin
                // Only an exception or ertn can pre-empt the wake-up target.
                if (excp_flush || ertn_flush) begin
                    state_q <= StPend;
                    buf_q   <= redir_tgt;
                end else if (has_int) begin
                    state_q <= StPend;
                end
            end else if (redir) begin
                buf_q   <= redir_tgt;
                state_q <= fetch_accept ? StRun : StPend;
            end else if (fetch_accept) begin
                state_q <= StRun;
            end
        end
    end

    // Stale data_ok right after reset is tolerated while the cache drains.
    a_data_ok_legal : assert property (@(posedge clk) disable iff (reset || mask_q != 3'd0)
        !(req_data_ok && out_cnt == 2'd0));

    a_out_cap : assert property (@(posedge clk) disable iff (reset)
        32'(out_cnt) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized + directed bench for fetch_redirect_ctrl against a queue-based reference model.
module tb_fetch_redirect_ctrl;

    localparam int          MAXO  = 2;
    localparam logic [31:0] RSTPC = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        excp_flush, excp_tlbrefill, ertn_flush, refetch_flush, idle_flush;
    logic        has_int, br_flush, seq_req, req_addr_ok, req_data_ok;
    logic [31:0] csr_eentry, csr_tlbrentry, csr_era, ws_pc, br_target, seq_pc;
    logic        req_valid, fetch_accept, resp_valid, resp_drop, redirect_pending, idle_locked;
    logic [31:0] req_addr;
    logic [1:0]  outstanding;

    fetch_redirect_ctrl #(
        .MAX_OUTSTANDING(MAXO),
        .RESET_PC       (RSTPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .excp_flush      (excp_flush),
        .excp_tlbrefill  (excp_tlbrefill),
        .csr_eentry      (csr_eentry),
        .csr_tlbrentry   (csr_tlbrentry),
        .ertn_flush      (ertn_flush),
        .csr_era         (csr_era),
        .refetch_flush   (refetch_flush),
        .idle_flush      (idle_flush),
        .ws_pc           (ws_pc),
        .has_int         (has_int),
        .br_flush        (br_flush),
        .br_target       (br_target),
        .seq_req         (seq_req),
        .seq_pc          (seq_pc),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_addr_ok     (req_addr_ok),
        .req_data_ok     (req_data_ok),
        .fetch_accept    (fetch_accept),
        .resp_valid      (resp_valid),
        .resp_drop       (resp_drop),
        .redirect_pending(redirect_pending),
        .idle_locked     (idle_locked),
        .outstanding     (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: in-flight requests as a queue of "cancelled" flags.
    bit          m_boot, m_pend, m_lock;
    logic [31:0] m_buf;
    bit          q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        excp_flush = 0; excp_tlbrefill = 0; ertn_flush = 0; refetch_flush = 0;
        idle_flush = 0; has_int = 0; br_flush = 0; seq_req = 0;
        req_addr_ok = 0; req_data_ok = 0;
    endtask

    task automatic step();
        bit          rd, e_valid, e_acc, e_rv, e_rdrop, igo;
        logic [31:0] tgt, e_addr;
        #2;
        if (reset) begin
            chk("rst_valid", 32'(req_valid), 0);
            chk("rst_addr", req_addr, RSTPC);
            chk("rst_accept", 32'(fetch_accept), 0);
            chk("rst_resp", 32'(resp_valid | resp_drop), 0);
            chk("rst_flags", 32'(redirect_pending | idle_locked), 0);
            chk("rst_out", 32'(outstanding), 0);
            m_boot = 1; m_pend = 0; m_lock = 0; q.delete();
        end else begin
            rd = 1;
            if (excp_flush) tgt = excp_tlbrefill ? csr_tlbrentry : csr_eentry;
            else if (ertn_flush) tgt = csr_era;
            else if (refetch_flush || idle_flush) tgt = ws_pc + 32'd4;
            else if (br_flush) tgt = br_target;
            else begin rd = 0; tgt = 0; end
            igo = idle_flush && !has_int;
            e_valid = !m_lock && !igo && (rd || m_pend || seq_req || m_boot)
                      && (q.size() < MAXO || req_data_ok);
            e_addr = rd ? tgt : m_pend ? m_buf : m_boot ? RSTPC : seq_pc;
            e_acc  = e_valid && req_addr_ok;
            e_rv    = req_data_ok && q.size() > 0 && !q[0];
            e_rdrop = req_data_ok && q.size() > 0 && q[0];
            chk("req_valid", 32'(req_valid), 32'(e_valid));
            if (e_valid) chk("req_addr", req_addr, e_addr);
            chk("fetch_accept", 32'(fetch_accept), 32'(e_acc));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("resp_drop", 32'(resp_drop), 32'(e_rdrop));
            chk("redirect_pending", 32'(redirect_pending), 32'(m_pend));
            chk("idle_locked", 32'(idle_locked), 32'(m_lock));
            chk("outstanding", 32'(outstanding), q.size());
            if (req_data_ok && q.size() > 0) void'(q.pop_front());
            if (rd) foreach (q[i]) q[i] = 1;
            if (e_acc) q.push_back(0);
            if (igo) begin
                m_lock = 1; m_pend = 0; m_boot = 0; m_buf = ws_pc + 32'd4;
            end else if (m_lock) begin
                if (excp_flush || ertn_flush) begin
                    m_lock = 0; m_pend = 1; m_buf = tgt;
                end else if (has_int) begin
                    m_lock = 0; m_pend = 1;
                end
            end else if (rd) begin
                m_boot = 0; m_pend = !e_acc; m_buf = tgt;
            end else if (e_acc) begin
                m_boot = 0; m_pend = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            seq_req = 0; req_addr_ok = 0; req_data_ok = 1;
            step();
        end
        req_data_ok = 0;
        chk("drain", 32'(outstanding), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1;
        csr_eentry = 0; csr_tlbrentry = 0; csr_era = 0; ws_pc = 0; br_target = 0; seq_pc = 0;
        m_buf = RSTPC;
        @(posedge clk); #1;
        step(); step();

        // Boot fetch then first sequential fetch.
        reset = 0; req_addr_ok = 1;
        #1; chk("boot_addr", req_addr, RSTPC); chk("boot_accept", 32'(fetch_accept), 1);
        step();
        seq_req = 1; seq_pc = 32'h1c000004;
        #1; chk("seq_addr", req_addr, 32'h1c000004);
        step();
        drain();

        // Triple flush, exception wins, held until accepted.
        excp_flush = 1; ertn_flush = 1; br_flush = 1; req_addr_ok = 0;
        csr_eentry = 32'h1c008000; csr_era = 32'h1c00aaa0; br_target = 32'h1c00bbb0;
        step();
        excp_flush = 0; ertn_flush = 0; br_flush = 0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("pend_hold", req_addr, 32'h1c008000);
            chk("pend_flag", 32'(redirect_pending), 1);
            step();
        end
        req_addr_ok = 1;
        #1; chk("pend_accept", 32'(fetch_accept), 1);
        step();
        req_addr_ok = 0;
        #1; chk("pend_clear", 32'(redirect_pending), 0);
        step();
        drain();

        // Two in flight, branch cancels both.
        seq_req = 1; req_addr_ok = 1; seq_pc = 32'h1c000010;
        step(); step();
        seq_req = 0; br_flush = 1; br_target = 32'h1c000100;
        #1; chk("cap_block", 32'(req_valid), 0);
        step();
        br_flush = 0; req_data_ok = 1;
        #1; chk("drop1", 32'(resp_drop), 1); chk("redir_issue", req_addr, 32'h1c000100);
        step();
        req_addr_ok = 0;
        #1; chk("drop2", 32'(resp_drop), 1);
        step();
        #1; chk("live_resp", 32'(resp_valid), 1);
        step();
        req_data_ok = 0;
        drain();

        // Idle lock until interrupt.
        idle_flush = 1; ws_pc = 32'h1c000040; seq_req = 1; req_addr_ok = 1;
        step();
        idle_flush = 0;
        for (int i = 0; i < 10; i++) begin
            #1; chk("idle_lock", 32'(idle_locked), 1); chk("idle_novalid", 32'(req_valid), 0);
            step();
        end
        has_int = 1;
        step();
        has_int = 0;
        #1; chk("idle_wake_addr", req_addr, 32'h1c000044);
        chk("idle_wake_valid", 32'(req_valid), 1);
        step();
        seq_req = 0;
        drain();

        // Newer refetch overwrites a pending branch target.
        br_flush = 1; br_target = 32'h100; req_addr_ok = 0;
        step();
        br_flush = 0; refetch_flush = 1; ws_pc = 32'h200;
        step();
        refetch_flush = 0; req_addr_ok = 1;
        #1; chk("refetch_over", req_addr, 32'h204);
        step();
        drain();

        // Reset with requests in flight; stale response not forwarded.
        seq_req = 1; req_addr_ok = 1;
        step(); step();
        seq_req = 0; req_addr_ok = 0; reset = 1;
        step();
        reset = 0; req_data_ok = 1;
        #1; chk("stale_resp", 32'(resp_valid), 0);
        step();
        req_data_ok = 0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            clr();
            reset          = ($urandom_range(0, 299) == 0);
            excp_flush     = ($urandom_range(0, 15) == 0);
            excp_tlbrefill = $urandom_range(0, 1) == 1;
            ertn_flush     = ($urandom_range(0, 19) == 0);
            refetch_flush  = ($urandom_range(0, 23) == 0);
            idle_flush     = ($urandom_range(0, 39) == 0);
            has_int        = m_lock ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
            br_flush       = ($urandom_range(0, 7) == 0);
            seq_req        = ($urandom_range(0, 3) != 0);
            req_addr_ok    = ($urandom_range(0, 2) != 0);
            req_data_ok    = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            csr_eentry     = $urandom & 32'hfffffffc;
            csr_tlbrentry  = $urandom & 32'hfffffffc;
            csr_era        = $urandom & 32'hfffffffc;
            br_target      = $urandom & 32'hfffffffc;
            seq_pc         = $urandom & 32'hfffffffc;
            ws_pc          = ($urandom_range(0, 9) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
            step();
        end
        clr();
        reset = 0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences all instruction-fetch requests into the inst-cache request port on behalf of the pre-IF/IF stages.
- Picks the fetch address each cycle from the prioritized flush and redirect sources, or from the sequential PC.
- Holds a redirect target until the cache accepts it, and enforces the idle lock.
- Tracks in-flight requests so that responses belonging to requests issued before a redirect are dropped, not forwarded to IF.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered cache requests; legal range 1..3.
- RESET_PC, 32'h1c000000: first fetch address after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- excp_flush  in  1  exception redirect
- excp_tlbrefill  in  1  qualifies excp_flush as a TLB refill
- csr_eentry  in  32  exception entry
- csr_tlbrentry  in  32  TLB refill entry
- ertn_flush  in  1  return-from-exception redirect
- csr_era  in  32  ertn target
- refetch_flush  in  1  refetch redirect; target is ws_pc+4
- idle_flush  in  1  idle instruction retired; target is ws_pc+4
- ws_pc  in  32  PC of the writeback instruction
- has_int  in  1  interrupt pending; releases the idle lock
- br_flush  in  1  branch/BTB mispredict redirect
- br_target  in  32  mispredict target
- seq_req  in  1  IF can take a new sequential fetch
- seq_pc  in  32  next sequential/predicted PC
- req_valid  out  1  cache request valid
- req_addr  out  32  cache request address
- req_addr_ok  in  1  cache accepted the request this cycle
- req_data_ok  in  1  cache returns data for the oldest outstanding request
- fetch_accept  out  1  pulse: req_addr accepted this cycle
- resp_valid  out  1  req_data_ok belongs to a live request
- resp_drop  out  1  req_data_ok belongs to a cancelled request
- redirect_pending  out  1  a buffered redirect awaits acceptance
- idle_locked  out  1  fetch is stopped by idle
- outstanding  out  2  live plus cancelled in-flight count

Behaviour:
- Reset: state RUN_BOOT; all outputs 0 except req_addr=RESET_PC; internal counters 0.
- RUN_BOOT: req_valid=1 with RESET_PC. On addr_ok -> RUN. A flush in this state behaves as in RUN.
- Redirect source priority (same-cycle arbitration):
  - excp_flush&excp_tlbrefill -> csr_tlbrentry
  - excp_flush -> csr_eentry
  - ertn_flush -> csr_era
  - refetch_flush|idle_flush -> ws_pc+4 (32-bit wrap)
  - br_flush -> br_target
  - br_flush is ignored when any other flush is asserted.
  - "redir" = any selected source this cycle; "redir_tgt" = its target.
- Address select:
  - redir -> redir_tgt
  - else PEND -> buffered target
  - else seq_pc
- req_valid = (redir || PEND || seq_req || RUN_BOOT) && !idle_locked && !(idle_flush && !has_int) && (outstanding<MAX_OUTSTANDING || req_data_ok).
- States: RUN_BOOT, RUN, PEND, IDLE.
  - RUN: redir && !(req_valid&&addr_ok) -> PEND, buffering redir_tgt. Idle rule takes precedence over this.
  - PEND: addr_ok && !redir -> RUN. A new redir overwrites the buffer (the newest redirect always wins) and stays in PEND unless accepted that cycle.
  - idle_flush && !has_int from any state -> IDLE with ws_pc+4 buffered.
    - IDLE: req_valid=0, idle_locked=1.
    - has_int -> PEND, which issues the buffered target.
    - A higher-priority flush in IDLE (excp/ertn) overwrites the buffer, clears the lock and goes to PEND.
  - idle_flush && has_int in the same cycle: no lock; treated as a refetch.
- Outstanding tracking:
  - live counter +1 on fetch_accept, -1 on data_ok; both in the same cycle -> net 0.
  - On redir, live-minus-(data_ok?1:0) moves to the cancel counter; live becomes 0, or 1 if the redirect request itself is accepted that cycle.
  - data_ok with cancel>0 -> resp_drop=1, resp_valid=0, cancel-1. Otherwise resp_valid=1.
  - Cancelled responses are always older than live ones (in-order cache).
  - outstanding = live+cancel, never exceeds MAX_OUTSTANDING.
  - data_ok with outstanding==0 is illegal (assertion).
- fetch_accept = req_valid && req_addr_ok. All outputs are combinational from state and inputs, except counters and state, which are registered.
- Reset mid-operation: all counters clear, lock clears, return to RUN_BOOT. data_ok arriving after reset is not forwarded (counter is 0; assertion is masked for 4 cycles after reset).

Test Plan:
- Reset, addr_ok=1 -> req_addr=0x1c000000, fetch_accept pulse; then seq_pc=0x1c000004 issued on seq_req.
- excp_flush+ertn_flush+br_flush same cycle, csr_eentry=0x1c008000, addr_ok=0 for 3 cycles -> PEND, req_addr=0x1c008000 held; accepted on cycle 4 -> RUN.
- Two requests accepted (outstanding=2), then br_flush to 0x1c000100 accepted -> next two data_ok give resp_drop, third gives resp_valid; outstanding never >2.
- idle_flush, ws_pc=0x1c000040, has_int=0 -> req_valid=0 and idle_locked=1 for 10 cycles; has_int=1 -> req_addr=0x1c000044.
- In PEND(br 0x100), refetch_flush ws_pc=0x200 arrives -> buffer becomes 0x204; accepted address is 0x204.
- reset asserted with 2 outstanding -> outstanding=0, req_addr=0x1c000000; stale data_ok does not produce resp_valid.
